mult8_ctrl: RTL and testbench
=============================

MULT8_CTRL -- requirements
Module: mult8_ctrl

Interface
REQ-001 The block SHALL have ports: Clk  in  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: Reset_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have ports: Run  in  1  start request, level, sampled in IDLE.
REQ-004 The block SHALL have ports: ClearA_LoadB  in  1  in IDLE: A<=0, X<=0, B<=Sw.
REQ-005 The block SHALL have ports: Sw  in  8  operand input, B source on load, S source on Run.
REQ-006 The block SHALL have ports: add_A  out  8  adder operand, equal to register A.
REQ-007 The block SHALL have ports: add_S  out  8  adder operand, S or (~S+1) mod 256.
REQ-008 The block SHALL have ports: add_sum  in  8  low 8 bits of the external 9-bit sign-extending adder (carry-in 0).
REQ-009 The block SHALL have ports: add_x  in  1  9th (sign) bit of that adder.
REQ-010 The block SHALL have ports: Aval, Bval  out  8 each  registers A and B; product = {Aval,Bval}.
REQ-011 The block SHALL have ports: Xval  out  1  sign-extension register X.
REQ-012 The block SHALL have ports: Busy, Done  out  1 each  status flags.

Function
REQ-013 The block SHALL implement states IDLE, ADD, SHIFT and DONE, plus a 3-bit iteration counter cnt.
REQ-014 In IDLE with Run=1, the block SHALL latch S<=Sw, clear A and X, keep B, set cnt=0 and go to ADD; Run takes priority over ClearA_LoadB in the same cycle.
REQ-015 In IDLE with Run=0 and ClearA_LoadB=1, the block SHALL set A=0, X=0, B=Sw.
REQ-016 In ADD with B[0]=1, the block SHALL load A<=add_sum and X<=add_x; with B[0]=0 it SHALL keep A and load X<=A[7]; it then goes to SHIFT.
REQ-017 add_A SHALL always equal A; add_S SHALL equal S when cnt<7 and (~S+1) mod 256 when cnt=7, so the final iteration subtracts.
REQ-018 In SHIFT, the block SHALL do an arithmetic right shift of {X,A,B}: A<={X,A[7:1]}, B<={A[0],B[7:1]}, X unchanged.
REQ-019 After SHIFT the block SHALL go to ADD with cnt+1 when cnt<7, and to DONE when cnt=7.
REQ-020 The operation SHALL last 16 cycles: Run sampled at edge 0; DONE entered at edge 16; Done=1 from edge 16.
REQ-021 Busy SHALL be 1 exactly in ADD and SHIFT; Done SHALL be 1 exactly in DONE.
REQ-022 DONE SHALL hold A, B and X and go to IDLE only when Run=0; holding Run high SHALL NOT restart the operation.
REQ-023 During Busy or DONE, Sw and ClearA_LoadB SHALL be ignored.
REQ-024 For signed 8-bit B (loaded) and S, {Aval,Bval} SHALL equal B*S as 16-bit two's complement.
REQ-025 Exception: when S=0x80 and B[7]=1, the result SHALL be (B*S - 32768) mod 65536, a documented limitation of the carry-in-0 adder.
REQ-026 A new Run without a reload SHALL use the current B, i.e. the previous low byte, as the multiplier.

Reset
REQ-027 When Reset_n=0, asynchronously: state=IDLE, cnt=0, A=B=S=0, X=0, Busy=0, Done=0; add_A and add_S then read 0.
REQ-028 A Reset_n assertion in any state, including mid-operation, SHALL abort with no partial result retained; operation resumes on the first edge after release.

Verification
REQ-029 Load B=0x03, Run with Sw=0x05 -> Done at edge 16, Aval=0x00, Bval=0x0F, Xval=0.
REQ-030 Load B=0x07, Run with Sw=0xFE -> Aval=0xFF, Bval=0xF2, Xval=1; Busy high for exactly 16 cycles.
REQ-031 Load B=0xFC, Run with Sw=0x03 -> 0xFFF4; then release Run and rerun with Sw=0x01 and no load -> B=0xF4, result 0xFFF4.
REQ-032 Load B=0x80, Run with Sw=0x80 -> 0xC000 per REQ-025; load B=0x7F, Run with Sw=0x80 -> 0xC080.
REQ-033 Hold Run high past Done for 20 cycles -> no restart, outputs stable; toggle ClearA_LoadB during DONE -> ignored.
REQ-034 Assert Reset_n=0 at cycle 7 of a run -> all outputs 0 immediately; after release with Run low -> IDLE, Busy=0.

Source files
------------

// File: rtl/mult8_ctrl.sv
// Signed 8x8 shift-add multiplier controller driving an external 9-bit sign-extending adder.
// Latency: 16 cycles from Run sampled in IDLE to Done; result held until Run drops.
// No backpressure: Sw/ClearA_LoadB are ignored while Busy or Done; Run held high never restarts.
module mult8_ctrl (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] Sw,
  output logic [7:0] add_A,
  output logic [7:0] add_S,
  input  logic [7:0] add_sum,
  input  logic       add_x,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       Xval,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q;
  logic [7:0] a_q, b_q, s_q;
  logic       x_q;

  localparam logic [2:0] LAST_ITER = 3'd7;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status flags; DONE waits for Run to drop so a held Run cannot restart.
  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_ADD;
      end
      ST_ADD: begin
        Busy    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        Busy    = 1'b1;
        state_d = (cnt_q == LAST_ITER) ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        Done = 1'b1;
        if (!Run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: load/clear in IDLE, conditional add, arithmetic shift of {X,A,B}.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      s_q   <= 8'd0;
      x_q   <= 1'b0;
      cnt_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Run wins over a simultaneous load; B is kept so a rerun reuses the old low byte.
          if (Run) begin
            s_q   <= Sw;
            a_q   <= 8'd0;
            x_q   <= 1'b0;
            cnt_q <= 3'd0;
          end else if (ClearA_LoadB) begin
            a_q <= 8'd0;
            x_q <= 1'b0;
            b_q <= Sw;
          end
        end
        ST_ADD: begin
          if (b_q[0]) begin
            a_q <= add_sum;
            x_q <= add_x;
          end else begin
            x_q <= a_q[7];
          end
        end
        ST_SHIFT: begin
          a_q <= {x_q, a_q[7:1]};
          b_q <= {a_q[0], b_q[7:1]};
          if (cnt_q != LAST_ITER) cnt_q <= cnt_q + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // The final iteration weighs the multiplier sign bit negatively, so S is negated there.
  always_comb begin
    add_A = a_q;
    add_S = (cnt_q == LAST_ITER) ? (~s_q + 8'd1) : s_q;
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;

endmodule

// File: tb/tb_mult8_ctrl.sv
module tb_mult8_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] Sw;
  logic [7:0] add_A, add_S, add_sum;
  logic       add_x;
  logic [7:0] Aval, Bval;
  logic       Xval, Busy, Done;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [7:0] b_model;

  mult8_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .Sw(Sw),
    .add_A(add_A), .add_S(add_S), .add_sum(add_sum), .add_x(add_x),
    .Aval(Aval), .Bval(Bval), .Xval(Xval), .Busy(Busy), .Done(Done)
  );

  // External 9-bit sign-extending adder, carry-in 0.
  logic [8:0] sum9;
  always_comb begin
    sum9    = {add_A[7], add_A} + {add_S[7], add_S};
    add_sum = sum9[7:0];
    add_x   = sum9[8];
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed product, with the documented -128 * negative-B deviation.
  function automatic logic [15:0] ref_prod(input logic [7:0] b, input logic [7:0] s);
    int p;
    p = int'($signed(b)) * int'($signed(s));
    if (s == 8'h80 && b[7]) p = p - 32768;
    return p[15:0];
  endfunction

  task automatic do_load(input logic [7:0] b);
    Sw = b;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    b_model = b;
    check("load_B", {24'd0, Bval}, {24'd0, b});
    check("load_A", {24'd0, Aval}, 32'd0);
    check("load_X", {31'd0, Xval}, 32'd0);
  endtask

  // Starts a run (optionally with a simultaneous load request), returns the product observed.
  task automatic do_run(input logic [7:0] s, input logic clr, output logic [15:0] prod);
    logic [15:0] exp;
    logic [7:0]  neg_s;
    int e;
    exp   = ref_prod(b_model, s);
    neg_s = 8'd0 - s;
    Sw = s;
    Run = 1'b1;
    ClearA_LoadB = clr;
    tick();
    e = 0;
    while (Busy && e < 40) begin
      if (e == 0)  check("addS_first", {24'd0, add_S}, {24'd0, s});
      if (e == 14) check("addS_last", {24'd0, add_S}, {24'd0, neg_s});
      Sw = 8'($urandom);
      ClearA_LoadB = 1'($urandom);
      e++;
      tick();
    end
    ClearA_LoadB = 1'b0;
    check("busy_cycles", e, 32'd16);
    check("done_flag", {31'd0, Done}, 32'd1);
    check("product", {16'd0, Aval, Bval}, {16'd0, exp});
    check("x_sign", {31'd0, Xval}, {31'd0, exp[15]});
    prod = {Aval, Bval};
    b_model = exp[7:0];
  endtask

  task automatic release_run();
    Run = 1'b0;
    tick();
    check("idle_done", {31'd0, Done}, 32'd0);
    check("idle_busy", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] prod;
    logic [7:0]  rb, rs;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    Sw = 8'h00;
    Reset_n = 1'b0;
    b_model = 8'h00;
    #3;
    check("rst_A", {24'd0, Aval}, 32'd0);
    check("rst_B", {24'd0, Bval}, 32'd0);
    check("rst_X", {31'd0, Xval}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_addA", {24'd0, add_A}, 32'd0);
    check("rst_addS", {24'd0, add_S}, 32'd0);
    #10;
    Reset_n = 1'b1;

    // Directed products.
    do_load(8'h03);
    do_run(8'h05, 1'b0, prod);
    check("d_03x05", {16'd0, prod}, 32'h000F);
    release_run();

    do_load(8'h07);
    do_run(8'hFE, 1'b0, prod);
    check("d_07xFE", {16'd0, prod}, 32'hFFF2);
    check("d_07xFE_X", {31'd0, Xval}, 32'd1);
    release_run();

    do_load(8'hFC);
    do_run(8'h03, 1'b0, prod);
    check("d_FCx03", {16'd0, prod}, 32'hFFF4);
    release_run();
    // Rerun without reload, with a competing load request that Run must override.
    do_run(8'h01, 1'b1, prod);
    check("d_rerun", {16'd0, prod}, 32'hFFF4);
    release_run();

    do_load(8'h80);
    do_run(8'h80, 1'b0, prod);
    check("d_80x80", {16'd0, prod}, 32'hC000);
    release_run();
    do_load(8'h7F);
    do_run(8'h80, 1'b0, prod);
    check("d_7Fx80", {16'd0, prod}, 32'hC080);

    // Run held high in DONE: no restart, loads ignored, result stable.
    for (int i = 0; i < 20; i++) begin
      Sw = 8'($urandom);
      ClearA_LoadB = 1'(i % 2);
      tick();
      check("hold_done", {31'd0, Done}, 32'd1);
      check("hold_prod", {16'd0, Aval, Bval}, 32'hC080);
    end
    ClearA_LoadB = 1'b0;
    release_run();
    check("idle_keep", {16'd0, Aval, Bval}, 32'hC080);

    // Randomized loads and reruns against the reference.
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rs = 8'($urandom);
      if (i == 3) rs = 8'h80;
      if (i % 3 != 2) do_load(rb);
      do_run(rs, 1'($urandom), prod);
      release_run();
    end

    // Reset in the middle of an operation.
    do_load(8'h55);
    Sw = 8'h33;
    Run = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", {31'd0, Busy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("mrst_A", {24'd0, Aval}, 32'd0);
    check("mrst_B", {24'd0, Bval}, 32'd0);
    check("mrst_X", {31'd0, Xval}, 32'd0);
    check("mrst_busy", {31'd0, Busy}, 32'd0);
    check("mrst_done", {31'd0, Done}, 32'd0);
    check("mrst_addA", {24'd0, add_A}, 32'd0);
    check("mrst_addS", {24'd0, add_S}, 32'd0);
    Run = 1'b0;
    #2;
    Reset_n = 1'b1;
    b_model = 8'h00;
    tick();
    check("post_busy", {31'd0, Busy}, 32'd0);
    check("post_done", {31'd0, Done}, 32'd0);
    check("post_prod", {16'd0, Aval, Bval}, 32'd0);

    // Normal operation resumes after reset.
    do_load(8'hF9);
    do_run(8'h0B, 1'b0, prod);
    check("d_F9x0B", {16'd0, prod}, 32'hFFB3);
    release_run();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
